instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 46 ++++
 rtl/instr_encoder_pack.sv | 49 ++++
 rtl/instr_encoder.sv | 105 ++++++++++
 tb/tb_instr_encoder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared mnemonic ids, opcode/funct table and FSM state type for the
// instruction encoder and any matching decoder.
package instr_encoder_pkg;

  localparam logic [4:0] M_ADD   = 5'd0,  M_ADDU = 5'd1,  M_SUB  = 5'd2,  M_SUBU = 5'd3,
                         M_AND   = 5'd4,  M_OR   = 5'd5,  M_SLL  = 5'd6,  M_SRL  = 5'd7,
                         M_SLT   = 5'd8,  M_JR   = 5'd9,  M_ADDI = 5'd10, M_ADDIU = 5'd11,
                         M_ANDI  = 5'd12, M_ORI  = 5'd13, M_LW   = 5'd14, M_SW   = 5'd15,
                         M_BEQ   = 5'd16, M_BNE  = 5'd17, M_BGT  = 5'd18, M_BGTE = 5'd19,
                         M_BLE   = 5'd20, M_BLEQ = 5'd21, M_SLTI = 5'd22, M_J    = 5'd23,
                         M_JAL   = 5'd24;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                         OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_LW    = 6'b100011,
                         OP_SW    = 6'b101011, OP_BEQ  = 6'b000100, OP_BNE   = 6'b000101,
                         OP_BGT   = 6'b000111, OP_BGTE = 6'b000001, OP_BLE   = 6'b000011,
                         OP_BLEQ  = 6'b000110, OP_SLTI = 6'b001010, OP_J     = 6'b010100,
                         OP_JAL   = 6'b010101;

  localparam logic [5:0] FN_ADD = 6'b100000, FN_ADDU = 6'b100001, FN_SUB = 6'b100010,
                         FN_SUBU = 6'b100011, FN_AND = 6'b100100, FN_OR  = 6'b100101,
                         FN_SLL = 6'b000000, FN_SRL  = 6'b000010, FN_SLT = 6'b101010,
                         FN_JR  = 6'b001000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational mnemonic-to-word packing; flags ids outside the table as illegal.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (mnem)
      M_ADD:   word = rtype(FN_ADD,  rs, rt, rd, 5'd0);
      M_ADDU:  word = rtype(FN_ADDU, rs, rt, rd, 5'd0);
      M_SUB:   word = rtype(FN_SUB,  rs, rt, rd, 5'd0);
      M_SUBU:  word = rtype(FN_SUBU, rs, rt, rd, 5'd0);
      M_AND:   word = rtype(FN_AND,  rs, rt, rd, 5'd0);
      M_OR:    word = rtype(FN_OR,   rs, rt, rd, 5'd0);
      M_SLL:   word = rtype(FN_SLL,  5'd0, rt, rd, shamt);
      M_SRL:   word = rtype(FN_SRL,  5'd0, rt, rd, shamt);
      M_SLT:   word = rtype(FN_SLT,  rs, rt, rd, 5'd0);
      M_JR:    word = rtype(FN_JR,   rs, 5'd0, 5'd0, 5'd0);
      M_ADDI:  word = itype(OP_ADDI,  rs, rt, imm);
      M_ADDIU: word = itype(OP_ADDIU, rs, rt, imm);
      M_ANDI:  word = itype(OP_ANDI,  rs, rt, imm);
      M_ORI:   word = itype(OP_ORI,   rs, rt, imm);
      M_LW:    word = itype(OP_LW,    rs, rt, imm);
      M_SW:    word = itype(OP_SW,    rs, rt, imm);
      M_BEQ:   word = itype(OP_BEQ,   rs, rt, imm);
      M_BNE:   word = itype(OP_BNE,   rs, rt, imm);
      M_BGT:   word = itype(OP_BGT,   rs, rt, imm);
      M_BGTE:  word = itype(OP_BGTE,  rs, rt, imm);
      M_BLE:   word = itype(OP_BLE,   rs, rt, imm);
      M_BLEQ:  word = itype(OP_BLEQ,  rs, rt, imm);
      M_SLTI:  word = itype(OP_SLTI,  rs, rt, imm);
      M_J:     word = jtype(OP_J,   target);
      M_JAL:   word = jtype(OP_JAL, target);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words with sequential addresses through a
// single-entry output register; counts illegal requests per program.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_RUN   | accepting requests until one marked last
//   S_DRAIN | waiting for the final word to leave the output register
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int ERRC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ERRC_W-1:0] err_count,
  output logic              done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ERRC_W-1:0] ERRC_ONE = {{(ERRC_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [31:0]       word;
  logic              legal;
  logic              accept;

  instr_pack u_pack (
    .mnem   (in_mnem),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .imm    (in_imm),
    .target (in_target),
    .word   (word),
    .legal  (legal)
  );

  // Ready whenever the output slot is empty or being drained this cycle.
  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      addr_cnt  <= '0;
      err       <= 1'b0;
      err_count <= '0;
      done      <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      // A new word overrides the clear above, giving back-to-back output.
      if (accept) begin
        if (legal) begin
          out_valid <= 1'b1;
          out_instr <= word;
          out_addr  <= addr_cnt;
          addr_cnt  <= addr_cnt + ADDR_ONE;
        end else begin
          err <= 1'b1;
          if (err_count != {ERRC_W{1'b1}}) err_count <= err_count + ERRC_ONE;
        end
      end
      case (state)
        S_IDLE: if (start) begin
          state     <= S_RUN;
          addr_cnt  <= base_addr;
          err_count <= '0;
        end
        S_RUN: if (accept && in_last) state <= S_DRAIN;
        S_DRAIN: if (!out_valid || out_ready) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table-driven reference encoder plus a cycle model of
// the handshake, checked every cycle, with directed and randomized programs.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int ERRC_W = 8;
  localparam int AMASK  = (1 << ADDR_W) - 1;
  localparam int EMAX   = (1 << ERRC_W) - 1;

  localparam int FN  [0:9]   = '{32, 33, 34, 35, 36, 37, 0, 2, 42, 8};
  localparam int OPC [10:24] = '{8, 9, 12, 13, 35, 43, 4, 5, 7, 1, 3, 6, 10, 20, 21};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [ERRC_W-1:0] err_count;
  logic              done;
  logic              busy;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;
  bit rand_sink = 0;
  bit sink_val = 1;
  int done_seen = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .ERRC_W(ERRC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_count(err_count), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    out_ready = rand_sink ? ($urandom_range(0, 3) != 0) : sink_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input int id, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
    longint w;
    if (id <= 9) begin
      if (id == 6 || id == 7) rs = 0; else sh = 0;
      if (id == 9) begin rt = 0; rd = 0; sh = 0; end
      w = longint'(rs) * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * 64 + FN[id];
    end else if (id <= 22) begin
      w = longint'(OPC[id]) * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    end else begin
      w = longint'(OPC[id]) * (1 << 26) + tgt;
    end
    return w[31:0];
  endfunction

  // Cycle model: phase 0 idle, 1 accepting, 2 draining.
  int          m_ph = 0;
  bit          m_ov = 0;
  logic [31:0] m_word = '0;
  int          m_addr = 0, m_cnt = 0, m_errc = 0;
  bit          m_err = 0, m_done = 0;

  always @(negedge clk) begin
    bit exp_ready, acc, old_ov;
    exp_ready = (m_ph == 1) && (!m_ov || out_ready);
    if (chk_en) begin
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, m_ph != 0);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_instr", out_instr, m_word);
        chk("out_addr", out_addr, m_addr);
      end
      chk("err", err, m_err);
      chk("err_count", err_count, m_errc);
      chk("done", done, m_done);
      if (done) done_seen++;
    end
    acc = in_valid && exp_ready;
    old_ov = m_ov;
    if (rst) begin
      m_ph = 0; m_ov = 0; m_word = '0; m_addr = 0; m_cnt = 0; m_errc = 0;
      m_err = 0; m_done = 0;
    end else begin
      m_err = 0;
      m_done = 0;
      if (m_ov && out_ready) m_ov = 0;
      if (acc) begin
        if (in_mnem < 25) begin
          m_ov = 1;
          m_word = ref_encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
          m_addr = m_cnt;
          m_cnt = (m_cnt + 1) & AMASK;
        end else begin
          m_err = 1;
          if (m_errc < EMAX) m_errc++;
        end
      end
      if (m_ph == 0 && start) begin
        m_ph = 1; m_cnt = base_addr; m_errc = 0;
      end else if (m_ph == 1 && acc && in_last) begin
        m_ph = 2;
      end else if (m_ph == 2 && (!old_ov || out_ready)) begin
        m_ph = 0; m_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_prog(input logic [ADDR_W-1:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int m, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input bit last);
    int n;
    n = 0;
    in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        nvec++; nerr++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 500) begin
        nvec++; nerr++;
        $display("FAIL idle_timeout actual=busy required=idle");
        break;
      end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    chk("ref_add",  ref_encode(0, 1, 2, 3, 0, 0, 0), 32'h00221820);
    chk("ref_addi", ref_encode(10, 4, 5, 0, 0, 'hFFFF, 0), 32'h2085FFFF);
    chk("ref_j",    ref_encode(23, 0, 0, 0, 0, 0, 'h100), 32'h50000100);
    chk("ref_srl",  ref_encode(7, 9, 1, 2, 3, 0, 0), 32'h000110C2);

    rst = 1'b1;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_busy", busy, 0);
    tick();

    // single add
    sink_val = 1;
    begin_prog(10'h010);
    send(0, 1, 2, 3, 0, 0, 0, 1);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_word", out_instr, 32'h00221820);
    chk("add_addr", out_addr, 10'h010);
    tick();
    wait_idle();

    // addi then j
    d0 = done_seen;
    begin_prog(10'h010);
    send(10, 4, 5, 0, 0, 'hFFFF, 0, 0);
    @(negedge clk);
    chk("addi_word", out_instr, 32'h2085FFFF);
    chk("addi_addr", out_addr, 10'h010);
    tick();
    send(23, 0, 0, 0, 0, 0, 'h100, 1);
    @(negedge clk);
    chk("j_word", out_instr, 32'h50000100);
    chk("j_addr", out_addr, 10'h011);
    tick();
    wait_idle();
    chk("done_once", done_seen - d0, 1);
    chk("busy_fell", busy, 0);

    // output stall then release
    begin_prog(10'h100);
    sink_val = 0;
    send(13, 7, 8, 0, 0, 'h1234, 0, 0);
    in_mnem = 5'd2; in_rs = 5'd9; in_rt = 5'd10; in_rd = 5'd11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_word", out_instr, 32'h34E81234);
    end
    tick();
    sink_val = 1;
    send(2, 9, 10, 11, 0, 0, 0, 0);
    @(negedge clk);
    chk("release_valid", out_valid, 1);
    chk("release_word", out_instr, 32'h012A5822);
    tick();
    send(4, 1, 1, 1, 0, 0, 0, 0);
    send(7, 3, 4, 5, 6, 0, 0, 0);
    send(9, 31, 31, 31, 31, 0, 0, 1);
    wait_idle();

    // illegal between legal ops
    begin_prog(10'h020);
    send(0, 1, 2, 3, 0, 0, 0, 0);
    send(27, 1, 2, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("illegal_err", err, 1);
    chk("illegal_cnt", err_count, 1);
    tick();
    send(5, 1, 2, 3, 0, 0, 0, 1);
    @(negedge clk);
    chk("after_illegal_addr", out_addr, 10'h021);
    tick();
    wait_idle();

    // address wrap
    begin_prog(10'h3FF);
    send(12, 1, 2, 0, 0, 'h00FF, 0, 0);
    @(negedge clk);
    chk("wrap_addr0", out_addr, 10'h3FF);
    tick();
    send(8, 1, 2, 3, 0, 0, 0, 1);
    @(negedge clk);
    chk("wrap_addr1", out_addr, 10'h000);
    tick();
    wait_idle();

    // reset with a pending word
    d0 = done_seen;
    begin_prog(10'h040);
    sink_val = 0;
    send(30, 0, 0, 0, 0, 0, 0, 0);
    send(0, 1, 2, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_errc", err_count, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_errc", err_count, 0);
    tick();
    tick();
    chk("post_rst_no_done", done_seen - d0, 0);
    sink_val = 1;

    // err_count saturation
    begin_prog(10'h000);
    for (int i = 0; i < 260; i++) send(25 + (i % 7), 0, 0, 0, 0, 0, 0, i == 259);
    wait_idle();
    chk("errc_saturate", err_count, EMAX);

    // randomized programs
    rand_sink = 1;
    for (int p = 0; p < 30; p++) begin
      begin_prog(ADDR_W'($urandom));
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        if ($urandom_range(0, 5) == 0) begin
          start = 1'b1;
          base_addr = ADDR_W'($urandom);
        end
        send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
             $urandom_range(0, (1 << 26) - 1), i == n - 1);
      end
      wait_idle();
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    rand_sink = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
